// File: rtl/msg_sched_ctrl_if.sv
// Handshake and data bundle between the block-padding front end, the
// message-schedule sequencer and the round/compression datapath.
interface msg_sched_ctrl_if;
    logic         start;
    logic [511:0] block_in;
    logic         busy;
    logic         w_valid;
    logic         w_ready;
    logic [5:0]   w_index;
    logic [31:0]  w_word;
    logic         done;

    // Sequencer side
    modport slave (
        input  start,
        input  block_in,
        input  w_ready,
        output busy,
        output w_valid,
        output w_index,
        output w_word,
        output done
    );

    // Front end / round logic side
    modport master (
        output start,
        output block_in,
        output w_ready,
        input  busy,
        input  w_valid,
        input  w_index,
        input  w_word,
        input  done
    );
endinterface

// File: rtl/msg_sched_ctrl.sv
// SHA-256 message schedule sequencer.
// Loads a 512-bit padded block, then streams W[0..63] over valid/ready.
// W[16..63] are expanded in place inside a 16-word circular window, so the
// slot being overwritten always holds W[t-16] when W[t] is produced.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; window contents are stale
// RUN    | presenting W[idx]; advances on each w_valid & w_ready
// DONE   | one-cycle done pulse after the W[63] transfer, then IDLE
module msg_sched_ctrl (
    input  logic             clk,
    input  logic             rst,
    msg_sched_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [5:0]  r_idx;
    logic [31:0] r_buf [16];

    logic        w_xfer;
    logic        w_expand;
    logic [3:0]  w_slot_m2;
    logic [3:0]  w_slot_m7;
    logic [3:0]  w_slot_m15;
    logic [3:0]  w_slot_cur;
    logic [31:0] w_word_calc;

    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign w_xfer   = (r_state == S_RUN) && bus.w_ready;
    assign w_expand = (r_idx >= 6'd16);

    // 4-bit wrap gives the mod-16 window addressing for free
    assign w_slot_cur = r_idx[3:0];
    assign w_slot_m2  = r_idx[3:0] - 4'd2;
    assign w_slot_m7  = r_idx[3:0] - 4'd7;
    assign w_slot_m15 = r_idx[3:0] - 4'd15;

    // Current schedule word: raw block word, or the expansion sum from registers only
    always_comb begin
        w_word_calc = r_buf[w_slot_cur];
        if (w_expand) begin
            w_word_calc = f_sigma1(r_buf[w_slot_m2])
                        + r_buf[w_slot_m7]
                        + f_sigma0(r_buf[w_slot_m15])
                        + r_buf[w_slot_cur];
        end
    end

    // Sequencer state, round index and schedule window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 6'd0;
            for (int k = 0; k < 16; k++) begin
                r_buf[k] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < 16; k++) begin
                            r_buf[k] <= bus.block_in[511 - 32*k -: 32];
                        end
                        r_idx   <= 6'd0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        if (w_expand) begin
                            r_buf[w_slot_cur] <= w_word_calc;
                        end
                        if (r_idx == 6'd63) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_idx   <= 6'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once
    assign bus.busy    = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.w_valid = (r_state == S_RUN);
    assign bus.done    = (r_state == S_DONE);
    assign bus.w_index = r_idx;
    assign bus.w_word  = w_word_calc;

endmodule

// File: tb/tb_msg_sched_ctrl.sv
// Scoreboard bench for msg_sched_ctrl: a golden schedule is queued when a
// start is accepted and compared word by word as the DUT presents it.
module tb_msg_sched_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    msg_sched_ctrl_if bus ();

    msg_sched_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    int m_state  = M_IDLE;
    int m_cnt    = 0;
    int m_stalls = 0;
    int n_accept = 0;
    int n_done   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic [37:0] q [$];
    logic [37:0] mon_exp;
    logic [31:0] gw  [64];
    logic [31:0] cap [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reference model of accept/advance/done; pushes the golden schedule on accept
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            q.delete();
        end else begin
            cyc++;
            case (m_state)
                M_IDLE: begin
                    if (bus.start) begin
                        for (int t = 0; t < 16; t++) gw[t] = bus.block_in[511 - 32*t -: 32];
                        for (int t = 16; t < 64; t++)
                            gw[t] = s1(gw[t-2]) + gw[t-7] + s0(gw[t-15]) + gw[t-16];
                        for (int t = 0; t < 64; t++) q.push_back({6'(t), gw[t]});
                        m_state  = M_RUN;
                        m_cnt    = 0;
                        m_stalls = 0;
                        acc_cyc  = cyc;
                        n_accept++;
                    end
                end
                M_RUN: begin
                    if (bus.w_ready) begin
                        if (q.size() > 0) void'(q.pop_front());
                        if (m_cnt == 63) m_state = M_DONE;
                        else m_cnt++;
                    end else begin
                        m_stalls++;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy",    bus.busy,    m_state != M_IDLE);
            chk("w_valid", bus.w_valid, m_state == M_RUN);
            chk("done",    bus.done,    m_state == M_DONE);
            if (bus.done) begin
                n_done++;
                chk("done_lat", cyc - acc_cyc, 64 + m_stalls);
            end
            if (m_state == M_RUN) begin
                chk("q_nonempty", q.size() != 0, 1'b1);
                mon_exp = (q.size() > 0) ? q[0] : '0;
                chk("w_index", bus.w_index, mon_exp[37:32]);
                chk("w_word",  bus.w_word,  mon_exp[31:0]);
                if (bus.w_ready) cap[bus.w_index] = bus.w_word;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
        return b;
    endfunction

    // mode 0: ready high; 1: backpressure; 2: stray start at idx 10
    task automatic run_block(input logic [511:0] b, input int mode);
        int d0;
        int forced;
        bit pulsed;
        d0     = n_done;
        forced = 0;
        pulsed = 0;
        for (int k = 0; k < 64; k++) cap[k] = 32'hDEAD_BEEF;
        bus.block_in = b;
        bus.start    = 1'b1;
        bus.w_ready  = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (n_done > d0 && m_state == M_IDLE) break;
            if (mode == 1) begin
                if (m_state == M_RUN && m_cnt == 20 && forced < 3) begin
                    bus.w_ready = 1'b0;
                    forced++;
                end else begin
                    bus.w_ready = 1'($urandom_range(0, 1));
                end
            end else if (mode == 2) begin
                if (m_state == M_RUN && m_cnt == 10 && !pulsed) begin
                    bus.start    = 1'b1;
                    bus.block_in = ~b;
                    pulsed       = 1;
                end else begin
                    bus.start = 1'b0;
                end
            end
            step();
        end
        bus.start   = 1'b0;
        bus.w_ready = 1'b1;
        chk("blk_done_count", n_done - d0, 1);
    endtask

    logic [511:0] abc;
    int d_save;
    int a0;
    int last_acc;
    int prev_acc;

    initial begin
        abc          = {32'h6162_6380, 448'h0, 32'h0000_0018};
        bus.start    = 1'b0;
        bus.block_in = '0;
        bus.w_ready  = 1'b0;
        #3;
        chk("rst_busy",    bus.busy,    1'b0);
        chk("rst_w_valid", bus.w_valid, 1'b0);
        chk("rst_done",    bus.done,    1'b0);
        chk("rst_w_index", bus.w_index, 6'd0);
        chk("rst_w_word",  bus.w_word,  32'd0);
        #10 rst = 1'b0;
        step();

        run_block(abc, 0);
        chk("abc_w0",  cap[0],  32'h6162_6380);
        chk("abc_w15", cap[15], 32'h0000_0018);
        chk("abc_w16", cap[16], 32'h6162_6380);
        chk("abc_w17", cap[17], 32'h000F_0000);

        run_block('0, 0);
        chk("zero_w63", cap[63], 32'h0);

        run_block(rand_block(), 1);
        run_block(rand_block(), 2);

        // abort at idx 30 with an asynchronous reset
        d_save       = n_done;
        bus.block_in = abc;
        bus.start    = 1'b1;
        bus.w_ready  = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 100 && !(m_state == M_RUN && m_cnt == 30); i++) step();
        chk("abort_at_idx", bus.w_index, 6'd30);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",    bus.busy,    1'b0);
        chk("abort_w_valid", bus.w_valid, 1'b0);
        chk("abort_done",    bus.done,    1'b0);
        chk("abort_w_index", bus.w_index, 6'd0);
        chk("abort_w_word",  bus.w_word,  32'd0);
        #3 rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("abort_no_done", n_done - d_save, 0);
        run_block(abc, 0);
        chk("post_abort_w0", cap[0], 32'h6162_6380);
        chk("post_abort_w17", cap[17], 32'h000F_0000);

        // back-to-back with start held high
        d_save       = n_done;
        a0           = n_accept;
        last_acc     = n_accept;
        prev_acc     = -1;
        bus.block_in = rand_block();
        bus.w_ready  = 1'b1;
        bus.start    = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (n_accept != last_acc) begin
                last_acc = n_accept;
                if (prev_acc >= 0) chk("b2b_gap", acc_cyc - prev_acc, 66);
                prev_acc     = acc_cyc;
                bus.block_in = rand_block();
                if (n_accept - a0 >= 3) bus.start = 1'b0;
            end
            if (n_done - d_save >= 3 && m_state == M_IDLE) break;
        end
        bus.start = 1'b0;
        chk("b2b_accepts", n_accept - a0, 3);
        chk("b2b_dones",   n_done - d_save, 3);

        for (int i = 0; i < 4; i++) step();
        chk("q_drained",  q.size(), 0);
        chk("done_total", n_done, n_accept - 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
